// File: rtl/card_ram_arbiter_if.sv
// rtl/card_ram_arbiter_if.sv - requester handshakes and card RAM pins shared by card_ram_arbiter
interface card_ram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] ram_din;
  logic              ram_ce;
  logic              ram_oe;
  logic              ram_we;
  logic              ram_drive;
  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_din,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output ram_a, ram_dout, ram_ce, ram_oe, ram_we, ram_drive, busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_din,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  ram_a, ram_dout, ram_ce, ram_oe, ram_we, ram_drive, busy, owner
  );
endinterface

// File: rtl/card_ram_arbiter.sv
// rtl/card_ram_arbiter.sv - CPU/DMA arbiter and setup/strobe/hold sequencer for the card RAM port
module card_ram_arbiter #(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 8,
  parameter int STROBE_CYCLES  = 2,
  parameter int MAX_CPU_STREAK = 4
) (
  input logic               mclk28,
  input logic               reset_in,
  card_ram_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]        state;
  logic [3:0]        strobe_cnt;
  logic [3:0]        streak;
  logic              cur_we;
  logic              grant_dma;
  logic              grant_cpu;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // CPU has priority unless it has already taken MAX_CPU_STREAK grants while DMA waited
  always_comb begin
    grant_dma = bus.dma_req && (!bus.cpu_req || streak == 4'(MAX_CPU_STREAK));
    grant_cpu = bus.cpu_req && !grant_dma;
    sel_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
    sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
    sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
  end

  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      state         <= IDLE;
      strobe_cnt    <= 4'd0;
      streak        <= 4'd0;
      cur_we        <= 1'b0;
      bus.owner     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.ram_a     <= '0;
      bus.ram_dout  <= '0;
      bus.ram_ce    <= 1'b0;
      bus.ram_oe    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_drive <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dma || grant_cpu) begin
            state         <= SETUP;
            bus.busy      <= 1'b1;
            bus.owner     <= grant_dma;
            bus.ram_a     <= sel_addr;
            bus.ram_dout  <= sel_wdata;
            cur_we        <= sel_we;
            bus.ram_ce    <= 1'b1;
            bus.ram_oe    <= !sel_we;
            bus.ram_drive <= sel_we;
            if (grant_cpu && bus.dma_req) begin
              if (streak != 4'(MAX_CPU_STREAK)) streak <= streak + 4'd1;
            end else begin
              streak <= 4'd0;
            end
          end
        end
        SETUP: begin
          state      <= STROBE;
          strobe_cnt <= 4'(STROBE_CYCLES - 1);
          bus.ram_we <= cur_we;
        end
        STROBE: begin
          if (strobe_cnt == 4'd0) begin
            state      <= HOLD;
            bus.ram_ce <= 1'b0;
            bus.ram_oe <= 1'b0;
            bus.ram_we <= 1'b0;
            if (!cur_we) begin
              if (bus.owner) bus.dma_rdata <= bus.ram_din;
              else           bus.cpu_rdata <= bus.ram_din;
            end
            if (bus.owner) bus.dma_ack <= 1'b1;
            else           bus.cpu_ack <= 1'b1;
          end else begin
            strobe_cnt <= strobe_cnt - 4'd1;
          end
        end
        default: begin
          // HOLD keeps the write driver on one extra cycle for data hold time
          state         <= IDLE;
          bus.cpu_ack   <= 1'b0;
          bus.dma_ack   <= 1'b0;
          bus.ram_drive <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_card_ram_arbiter.sv
// tb/tb_card_ram_arbiter.sv - randomized self-checking bench for card_ram_arbiter
module tb_card_ram_arbiter;
  localparam int AW   = 18;
  localparam int DW   = 8;
  localparam int SC   = 2;
  localparam int MAXS = 4;

  logic mclk28 = 1'b0;
  logic reset_in;
  always #18 mclk28 = ~mclk28;

  card_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  card_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  card_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(SC), .MAX_CPU_STREAK(MAXS)) dut (
    .mclk28(mclk28), .reset_in(reset_in), .bus(bus)
  );
  card_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(1), .MAX_CPU_STREAK(MAXS)) dut1 (
    .mclk28(mclk28), .reset_in(reset_in), .bus(bus1)
  );

  // requester drive state, index 0 = CPU, 1 = DMA
  logic          a_req   [2];
  logic          a_we    [2];
  logic [AW-1:0] a_addr  [2];
  logic [DW-1:0] a_wdata [2];
  logic [DW-1:0] sim_mem [64];
  logic [DW-1:0] ref_mem [64];
  logic          f_req;
  logic [AW-1:0] f_addr;

  assign bus.cpu_req   = a_req[0];
  assign bus.cpu_we    = a_we[0];
  assign bus.cpu_addr  = a_addr[0];
  assign bus.cpu_wdata = a_wdata[0];
  assign bus.dma_req   = a_req[1];
  assign bus.dma_we    = a_we[1];
  assign bus.dma_addr  = a_addr[1];
  assign bus.dma_wdata = a_wdata[1];
  assign bus.ram_din   = sim_mem[bus.ram_a[5:0]];

  assign bus1.cpu_req   = f_req;
  assign bus1.cpu_we    = 1'b0;
  assign bus1.cpu_addr  = f_addr;
  assign bus1.cpu_wdata = '0;
  assign bus1.dma_req   = 1'b0;
  assign bus1.dma_we    = 1'b0;
  assign bus1.dma_addr  = '0;
  assign bus1.dma_wdata = '0;
  assign bus1.ram_din   = (bus1.ram_a == 18'h00001) ? 8'h22 : 8'h11;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_txn(input int w);
    a_req[w]   = 1'b1;
    a_we[w]    = 1'($urandom_range(0, 1));
    a_addr[w]  = AW'($urandom);
    a_wdata[w] = DW'($urandom);
  endtask

  task automatic agent_step(input int w, input logic rel, input logic granted);
    if (rel) begin
      if ($urandom_range(0, 1) == 1) new_txn(w);
      else a_req[w] = 1'b0;
    end else if (granted) begin
      a_addr[w]  = AW'($urandom);
      a_wdata[w] = DW'($urandom);
      a_we[w]    = 1'($urandom_range(0, 1));
    end else if (!a_req[w] && $urandom_range(0, 3) == 0) begin
      new_txn(w);
    end
  endtask

  // transaction-level model: one grant at a time, phases placed by offset from the grant cycle
  task automatic random_phase(input int ncyc);
    int            nxt_arb, g_cyc, d, streak_m, w;
    logic          g_valid, g_dma, g_we, c_rel, d_rel, e_cack, e_dack, gd, gc, owner_m;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, g_rd, cpu_rd_m, dma_rd_m;
    nxt_arb = 0; g_cyc = 0; streak_m = 0; g_valid = 0; g_dma = 0; g_we = 0;
    c_rel = 0; d_rel = 0; owner_m = 0; g_addr = '0; g_wdata = '0; g_rd = '0;
    cpu_rd_m = '0; dma_rd_m = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        @(posedge mclk28);
        #1;
      end
      d      = g_valid ? k - g_cyc : -1;
      e_cack = (d == 2 + SC) && !g_dma;
      e_dack = (d == 2 + SC) && g_dma;
      if (d >= 1) owner_m = g_dma;
      if (d == 2 + SC && !g_we) begin
        if (g_dma) dma_rd_m = g_rd;
        else       cpu_rd_m = g_rd;
      end
      check("busy",      bus.busy,      d >= 1 && d <= 2 + SC);
      check("ram_ce",    bus.ram_ce,    d >= 1 && d <= 1 + SC);
      check("ram_oe",    bus.ram_oe,    !g_we && d >= 1 && d <= 1 + SC);
      check("ram_we",    bus.ram_we,    g_we && d >= 2 && d <= 1 + SC);
      check("ram_drive", bus.ram_drive, g_we && d >= 1 && d <= 2 + SC);
      check("cpu_ack",   bus.cpu_ack,   e_cack);
      check("dma_ack",   bus.dma_ack,   e_dack);
      check("owner",     bus.owner,     owner_m);
      check("cpu_rdata", bus.cpu_rdata, cpu_rd_m);
      check("dma_rdata", bus.dma_rdata, dma_rd_m);
      if (d >= 1 && d <= 2 + SC) begin
        check("ram_a",    bus.ram_a,    g_addr);
        check("ram_dout", bus.ram_dout, g_wdata);
      end
      if (bus.ram_we === 1'b1) sim_mem[bus.ram_a[5:0]] = bus.ram_dout;

      agent_step(0, c_rel, !g_dma && d >= 1 && d <= 2 + SC);
      agent_step(1, d_rel,  g_dma && d >= 1 && d <= 2 + SC);
      c_rel = e_cack;
      d_rel = e_dack;

      if (k == nxt_arb) begin
        gd = a_req[1] && (!a_req[0] || streak_m == MAXS);
        gc = a_req[0] && !gd;
        if (gd || gc) begin
          w       = gd ? 1 : 0;
          g_valid = 1'b1;
          g_cyc   = k;
          g_dma   = gd;
          g_we    = a_we[w];
          g_addr  = a_addr[w];
          g_wdata = a_wdata[w];
          if (g_we) ref_mem[g_addr[5:0]] = g_wdata;
          else      g_rd = ref_mem[g_addr[5:0]];
          if (gc && a_req[1]) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
          else                streak_m = 0;
          nxt_arb = k + 3 + SC;
        end else begin
          nxt_arb = k + 1;
        end
      end
    end
    a_req[0] = 1'b0;
    a_req[1] = 1'b0;
    repeat (8) @(posedge mclk28);
    #1;
  endtask

  task automatic starvation_phase;
    int acks = 0;
    int cyc  = 0;
    reset_in = 1'b1;
    @(posedge mclk28);
    #1;
    reset_in = 1'b0;
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 18'h00011;
    a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 18'h00022;
    while (acks < 20 && cyc < 200) begin
      @(posedge mclk28);
      #1;
      cyc++;
      if (bus.cpu_ack || bus.dma_ack) begin
        check("starve_order", bus.dma_ack, acks % 5 == 4);
        check("starve_excl",  bus.cpu_ack & bus.dma_ack, 1'b0);
        acks++;
      end
    end
    check("starve_acks", acks, 20);
    a_req[0] = 1'b0;
    a_req[1] = 1'b0;
    repeat (8) @(posedge mclk28);
    #1;
  endtask

  task automatic reset_midaccess;
    int waited = 0;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 18'h00155; a_wdata[0] = 8'h3C;
    while (bus.ram_we !== 1'b1 && waited < 20) begin
      @(posedge mclk28);
      #1;
      waited++;
    end
    check("rst_mid_strobe", waited < 20, 1'b1);
    reset_in = 1'b1;
    a_req[0] = 1'b0;
    @(posedge mclk28);
    #1;
    check("rst_mid_we",    bus.ram_we,    1'b0);
    check("rst_mid_ce",    bus.ram_ce,    1'b0);
    check("rst_mid_drive", bus.ram_drive, 1'b0);
    check("rst_mid_busy",  bus.busy,      1'b0);
    check("rst_mid_rdata", bus.cpu_rdata, 8'h00);
    check("rst_mid_a",     bus.ram_a,     18'h0);
    reset_in = 1'b0;
    repeat (6) begin
      @(posedge mclk28);
      #1;
      check("rst_mid_noack", bus.cpu_ack, 1'b0);
    end
  endtask

  task automatic fast_build_reads;
    f_addr = 18'h00000;
    f_req  = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge mclk28);
      #1;
      check("f_oe",  bus1.ram_oe,  t == 1 || t == 2 || t == 5 || t == 6);
      check("f_ack", bus1.cpu_ack, t == 3 || t == 7);
      if (bus1.ram_oe === 1'b1) check("f_addr", bus1.ram_a, (t < 4) ? 18'h0 : 18'h1);
      if (t == 3) check("f_rdata0", bus1.cpu_rdata, 8'h11);
      if (t == 7) check("f_rdata1", bus1.cpu_rdata, 8'h22);
      if (t == 4) f_addr = 18'h00001;
      if (t == 8) f_req = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    reset_in = 1'b1;
    f_req    = 1'b0;
    f_addr   = '0;
    for (int i = 0; i < 2; i++) begin
      a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      v = DW'($urandom);
      sim_mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge mclk28);
    #1;
    check("rst_busy",  bus.busy,      1'b0);
    check("rst_owner", bus.owner,     1'b0);
    check("rst_ce",    bus.ram_ce,    1'b0);
    check("rst_oe",    bus.ram_oe,    1'b0);
    check("rst_we",    bus.ram_we,    1'b0);
    check("rst_drive", bus.ram_drive, 1'b0);
    check("rst_acks",  {bus.cpu_ack, bus.dma_ack}, 2'b00);
    check("rst_a",     bus.ram_a,     18'h0);
    check("rst_dout",  bus.ram_dout,  8'h00);
    reset_in = 1'b0;
    random_phase(3000);
    starvation_phase();
    reset_midaccess();
    fast_build_reads();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
